// File: rtl/iobus_uart_pkg.sv
// Shared definitions for the IOBUS UART transmitter: register offsets,
// STATUS bit positions, TX state encoding and the divisor clamp helper.
package iobus_uart_pkg;

   localparam logic [1:0] REG_TXDATA  = 2'd0;
   localparam logic [1:0] REG_STATUS  = 2'd1;
   localparam logic [1:0] REG_BAUDDIV = 2'd2;
   localparam logic [1:0] REG_CTRL    = 2'd3;

   localparam int ST_BUSY      = 0;
   localparam int ST_FULL      = 1;
   localparam int ST_EMPTY     = 2;
   localparam int ST_OVF       = 3;
   localparam int ST_LEVEL_LSB = 8;

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;

   // A bit period shorter than two cycles is not meaningful, so 0 and 1 act as 2.
   function automatic logic [15:0] eff_div(input logic [15:0] div);
      return (div < 16'd2) ? 16'd2 : div;
   endfunction

endpackage

// File: rtl/iobus_fifo.sv
// Synchronous FIFO with first-word-fall-through read data; pushes into a full
// FIFO and pops from an empty one are ignored.
module iobus_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] wr_data,
   output logic [WIDTH-1:0] rd_data,
   output logic             full,
   output logic             empty,
   output logic [AW:0]      level
);

   localparam logic [AW:0] FULL_LVL = DEPTH[AW:0];

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             push_ok;
   logic             pop_ok;

   assign full    = (level == FULL_LVL);
   assign empty   = (level == '0);
   assign push_ok = push && !full;
   assign pop_ok  = pop && !empty;
   assign rd_data = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= wr_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + AW'(1);
         if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
         level <= level + {{AW{1'b0}}, push_ok} - {{AW{1'b0}}, pop_ok};
      end
   end

endmodule

// File: rtl/iobus_uart_tx.sv
// Memory-mapped 8N1 UART transmitter on the MCU IOBUS.
// Optional TX-empty interrupt and CTRL register: define IOBUS_UART_IRQ_EN.
//
//   state | meaning
//   IDLE  | line high, waiting for a queued byte
//   START | start bit (line low) for one bit period
//   DATA  | eight data bits, LSB first
//   STOP  | stop bit (line high); chains straight into START if more bytes wait
module iobus_uart_tx
   import iobus_uart_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR   = 32'h1100_0040,
   parameter int          CLK_RATE    = 50,
   parameter int          BAUD        = 115200,
   parameter int          FIFO_DEPTH  = 8,
   parameter int          DEFAULT_DIV = CLK_RATE * 1_000_000 / BAUD
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] iobus_addr,
   input  logic [31:0] iobus_out,
   input  logic        iobus_wr,
   output logic [31:0] iobus_in,
   output logic        rd_hit,
   output logic        tx_out,
   output logic        tx_irq
);

   localparam int LW = $clog2(FIFO_DEPTH) + 1;

   tx_state_t   state;
   logic [15:0] cnt;
   logic [15:0] div_lat;
   logic [2:0]  bit_idx;
   logic [7:0]  shreg;

   logic [15:0] baud_div;
   logic        ovf;
   logic        push_q;
   logic [7:0]  push_data_q;

   logic        wr_hit;
   logic [1:0]  reg_sel;
   logic        fifo_pop;
   logic        fifo_full;
   logic        fifo_empty;
   logic [7:0]  fifo_rd;
   logic [LW-1:0] fifo_level;
   logic [31:0] status;
   logic [31:0] ctrl_rd;
   logic        unused_bits;

   assign rd_hit      = (iobus_addr[31:4] == BASE_ADDR[31:4]);
   assign wr_hit      = iobus_wr && rd_hit;
   assign reg_sel     = iobus_addr[3:2];
   assign unused_bits = ^{iobus_addr[1:0], iobus_out[31:16]};

   // Pop while idle, or at the last cycle of a stop bit so frames chain without a gap.
   assign fifo_pop = !fifo_empty && ((state == IDLE) || (state == STOP && cnt == 16'd0));

   iobus_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push    (push_q),
      .pop     (fifo_pop),
      .wr_data (push_data_q),
      .rd_data (fifo_rd),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .level   (fifo_level)
   );

   // Bus writes to TXDATA are staged one cycle before entering the FIFO.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         push_q      <= 1'b0;
         push_data_q <= 8'd0;
         baud_div    <= 16'(DEFAULT_DIV);
         ovf         <= 1'b0;
      end else begin
         push_q      <= wr_hit && (reg_sel == REG_TXDATA);
         push_data_q <= iobus_out[7:0];
         if (push_q && fifo_full)
            ovf <= 1'b1;
         else if (wr_hit && reg_sel == REG_STATUS && iobus_out[ST_OVF])
            ovf <= 1'b0;
         if (wr_hit && reg_sel == REG_BAUDDIV)
            baud_div <= iobus_out[15:0];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         cnt     <= 16'd0;
         div_lat <= 16'd2;
         bit_idx <= 3'd0;
         shreg   <= 8'd0;
         tx_out  <= 1'b1;
      end else begin
         case (state)
            IDLE: begin
               if (fifo_pop) begin
                  shreg   <= fifo_rd;
                  div_lat <= eff_div(baud_div);
                  cnt     <= eff_div(baud_div) - 16'd1;
                  tx_out  <= 1'b0;
                  state   <= START;
               end
            end
            START: begin
               if (cnt == 16'd0) begin
                  cnt     <= div_lat - 16'd1;
                  bit_idx <= 3'd0;
                  tx_out  <= shreg[0];
                  shreg   <= {1'b0, shreg[7:1]};
                  state   <= DATA;
               end else begin
                  cnt <= cnt - 16'd1;
               end
            end
            DATA: begin
               if (cnt == 16'd0) begin
                  cnt <= div_lat - 16'd1;
                  if (bit_idx == 3'd7) begin
                     tx_out <= 1'b1;
                     state  <= STOP;
                  end else begin
                     bit_idx <= bit_idx + 3'd1;
                     tx_out  <= shreg[0];
                     shreg   <= {1'b0, shreg[7:1]};
                  end
               end else begin
                  cnt <= cnt - 16'd1;
               end
            end
            STOP: begin
               if (cnt == 16'd0) begin
                  if (fifo_pop) begin
                     shreg   <= fifo_rd;
                     div_lat <= eff_div(baud_div);
                     cnt     <= eff_div(baud_div) - 16'd1;
                     tx_out  <= 1'b0;
                     state   <= START;
                  end else begin
                     state <= IDLE;
                  end
               end else begin
                  cnt <= cnt - 16'd1;
               end
            end
            default: begin
               state  <= IDLE;
               tx_out <= 1'b1;
            end
         endcase
      end
   end

`ifdef IOBUS_UART_IRQ_EN
   logic irq_en;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         irq_en <= 1'b0;
         tx_irq <= 1'b0;
      end else begin
         if (wr_hit && reg_sel == REG_CTRL) irq_en <= iobus_out[0];
         tx_irq <= irq_en && fifo_empty && (state == IDLE);
      end
   end

   assign ctrl_rd = {31'd0, irq_en};
`else
   assign tx_irq  = 1'b0;
   assign ctrl_rd = 32'd0;
`endif

   always_comb begin
      status                       = 32'd0;
      status[ST_BUSY]              = (state != IDLE);
      status[ST_FULL]              = fifo_full;
      status[ST_EMPTY]             = fifo_empty;
      status[ST_OVF]               = ovf;
      status[ST_LEVEL_LSB +: 4]    = 4'(fifo_level);
   end

   always_comb begin
      iobus_in = 32'd0;
      if (rd_hit) begin
         case (reg_sel)
            REG_STATUS:  iobus_in = status;
            REG_BAUDDIV: iobus_in = {16'd0, baud_div};
            REG_CTRL:    iobus_in = ctrl_rd;
            default:     iobus_in = 32'd0;
         endcase
      end
   end

endmodule
